// File: rtl/vgachargen_pkg.sv
//==============================================================================
// Module   : vgachargen_pkg
// Brief    : Shared constants, FSM encoding and address decode for the
//            text-mode VGA character generator APB register interface.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package vgachargen_pkg;

    // Region base addresses (byte addresses, word aligned)
    localparam logic [31:0] c_chmap_base  = 32'h0000_0000;
    localparam logic [31:0] c_colmap_base = 32'h0000_1000;
    localparam logic [31:0] c_glyph_base  = 32'h0000_2000;
    localparam logic [31:0] c_ctrl_addr   = 32'h0000_3000;

    // Glyph geometry: 128-bit glyph rows split into four 32-bit APB slices
    localparam int unsigned c_glyph_w       = 128;
    localparam int unsigned c_glyph_slice_w = 32;

    // FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle     = 3'd0;
    localparam state_t c_st_decode   = 3'd1;
    localparam state_t c_st_map_wr   = 3'd2;
    localparam state_t c_st_map_rd   = 3'd3;
    localparam state_t c_st_gly_rd   = 3'd4;
    localparam state_t c_st_gly_wait = 3'd5;
    localparam state_t c_st_gly_wr   = 3'd6;
    localparam state_t c_st_resp     = 3'd7;

    // Address regions
    typedef logic [2:0] region_t;
    localparam region_t c_rg_none   = 3'd0;
    localparam region_t c_rg_chmap  = 3'd1;
    localparam region_t c_rg_colmap = 3'd2;
    localparam region_t c_rg_glyph  = 3'd3;
    localparam region_t c_rg_ctrl   = 3'd4;

    // Classify a byte address; the two low address bits never matter.
    // Unsigned wrap of (a - base) makes addresses below a base fall out.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] map_bytes,
                                              input logic [31:0] glyph_bytes);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if ((a - c_chmap_base) < map_bytes)
            decode_region = c_rg_chmap;
        else if ((a - c_colmap_base) < map_bytes)
            decode_region = c_rg_colmap;
        else if ((a - c_glyph_base) < glyph_bytes)
            decode_region = c_rg_glyph;
        else if (a == c_ctrl_addr)
            decode_region = c_rg_ctrl;
        else
            decode_region = c_rg_none;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vgachargen_lane_seq.sv
//==============================================================================
// Module   : vgachargen_lane_seq
// Brief    : Byte-strobe sequencer. Picks the lowest pending lane and returns
//            the strobe mask with that lane retired.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vgachargen_lane_seq (
    input  logic [3:0] i_strb,
    output logic [1:0] o_lane,
    output logic [3:0] o_strb_rest,
    output logic       o_last
);

    // Lowest set strobe wins so lanes are written in ascending order
    always_comb begin
        o_lane = 2'd0;
        if (i_strb[0])
            o_lane = 2'd0;
        else if (i_strb[1])
            o_lane = 2'd1;
        else if (i_strb[2])
            o_lane = 2'd2;
        else if (i_strb[3])
            o_lane = 2'd3;
        o_strb_rest = i_strb & ~(4'b0001 << o_lane);
        o_last      = (o_strb_rest == 4'b0000);
    end

endmodule

`default_nettype wire

// File: rtl/vgachargen_apb_regif.sv
//==============================================================================
// Module   : vgachargen_apb_regif
// Brief    : APB4 slave driving the char map, colour map, glyph table and
//            enable of the text-mode VGA top. Byte-wide map accesses and
//            128-bit glyph read-modify-writes, all in the system clock domain.
// Config   : VGACHARGEN_APB_RDBACK_EN - when defined, map and glyph reads
//            fetch from memory; otherwise they complete at once returning 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vgachargen_apb_regif
    import vgachargen_pkg::*;
#(
    parameter int unsigned MAP_WORDS   = 2400,
    parameter int unsigned GLYPH_COUNT = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         psel,
    input  logic         penable,
    input  logic         pwrite,
    input  logic [31:0]  paddr,
    input  logic [31:0]  pwdata,
    input  logic [3:0]   pstrb,
    output logic [31:0]  prdata,
    output logic         pready,
    output logic         pslverr,
    output logic [11:0]  ch_map_addr_o,
    output logic [7:0]   ch_map_data_o,
    output logic         ch_map_wen_o,
    input  logic [7:0]   ch_map_data_i,
    output logic [11:0]  col_map_addr_o,
    output logic [7:0]   col_map_data_o,
    output logic         col_map_wen_o,
    input  logic [7:0]   col_map_data_i,
    output logic [6:0]   ch_t_rw_addr_o,
    output logic [127:0] ch_t_rw_data_o,
    output logic         ch_t_rw_wen_o,
    input  logic [127:0] ch_t_rw_data_i,
    output logic         en_o
);

`ifdef VGACHARGEN_APB_RDBACK_EN
    localparam bit c_rdback = 1'b1;
`else
    localparam bit c_rdback = 1'b0;
`endif

    state_t         r_state;
    region_t        r_region;
    logic           r_write;
    logic [11:0]    r_map_addr;
    logic [6:0]     r_gidx;
    logic [1:0]     r_slice;
    logic [31:0]    r_wdata;
    logic [3:0]     r_strb;
    logic [2:0]     r_cnt;
    logic [31:0]    r_rdata;
    logic [127:0]   r_glyph;
    logic           r_en;
    logic           r_err;

    region_t        w_region;
    logic [1:0]     w_lane;
    logic [3:0]     w_strb_rest;
    logic           w_last;
    logic [1:0]     w_map_offset;
    logic [11:0]    w_map_addr;
    logic [7:0]     w_map_rd_data;
    logic [1:0]     w_cap_lane;
    logic [127:0]   w_glyph_merged;
    logic [31:0]    w_glyph_slice;

    assign w_region = decode_region(paddr, 32'(MAP_WORDS), 32'(GLYPH_COUNT * 16));

    vgachargen_lane_seq u_lane_seq (
        .i_strb      (r_strb),
        .o_lane      (w_lane),
        .o_strb_rest (w_strb_rest),
        .o_last      (w_last)
    );

    // Map port address: write lanes follow the strobe sequencer, reads walk +0..+3
    assign w_map_offset  = (r_state == c_st_map_rd) ? r_cnt[1:0] : w_lane;
    assign w_map_addr    = r_map_addr + {10'd0, w_map_offset};
    assign w_map_rd_data = (r_region == c_rg_colmap) ? col_map_data_i : ch_map_data_i;
    // Byte k is on the read port one cycle after address +k, i.e. at r_cnt = k+1
    assign w_cap_lane    = r_cnt[1:0] - 2'd1;
    assign w_glyph_slice = ch_t_rw_data_i[c_glyph_slice_w * int'(r_slice) +: c_glyph_slice_w];

    // Replace the strobed bytes of the addressed slice in the fetched glyph row
    always_comb begin
        w_glyph_merged = ch_t_rw_data_i;
        for (int l = 0; l < 4; l++) begin
            if (r_strb[l])
                w_glyph_merged[c_glyph_slice_w * int'(r_slice) + 8 * l +: 8] = r_wdata[8 * l +: 8];
        end
    end

    // Transfer sequencing, request capture and result collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_region   <= c_rg_none;
            r_write    <= 1'b0;
            r_map_addr <= 12'd0;
            r_gidx     <= 7'd0;
            r_slice    <= 2'd0;
            r_wdata    <= 32'd0;
            r_strb     <= 4'd0;
            r_cnt      <= 3'd0;
            r_rdata    <= 32'd0;
            r_glyph    <= 128'd0;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (psel)
                        r_state <= c_st_decode;
                end
                c_st_decode: begin
                    if (!psel) begin
                        r_state <= c_st_idle;
                    end else if (penable) begin
                        r_region   <= w_region;
                        r_write    <= pwrite;
                        r_map_addr <= {paddr[11:2], 2'b00};
                        r_gidx     <= paddr[10:4];
                        r_slice    <= paddr[3:2];
                        r_wdata    <= pwdata;
                        r_strb     <= pwrite ? pstrb : 4'd0;
                        r_cnt      <= 3'd0;
                        r_rdata    <= 32'd0;
                        r_err      <= 1'b0;
                        case (w_region)
                            c_rg_chmap, c_rg_colmap: begin
                                if (pwrite)
                                    r_state <= (pstrb == 4'd0) ? c_st_resp : c_st_map_wr;
                                else
                                    r_state <= c_rdback ? c_st_map_rd : c_st_resp;
                            end
                            c_rg_glyph: begin
                                r_state <= (pwrite || c_rdback) ? c_st_gly_rd : c_st_resp;
                            end
                            c_rg_ctrl: begin
                                if (pwrite && pstrb[0])
                                    r_en <= pwdata[0];
                                if (!pwrite)
                                    r_rdata <= {31'd0, r_en};
                                r_state <= c_st_resp;
                            end
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= c_st_resp;
                            end
                        endcase
                    end
                end
                c_st_map_wr: begin
                    r_strb <= w_strb_rest;
                    if (w_last)
                        r_state <= c_st_resp;
                end
                c_st_map_rd: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0)
                        r_rdata[8 * w_cap_lane +: 8] <= w_map_rd_data;
                    if (r_cnt == 3'd4)
                        r_state <= c_st_resp;
                end
                c_st_gly_rd: begin
                    r_state <= c_st_gly_wait;
                end
                c_st_gly_wait: begin
                    if (r_write) begin
                        r_glyph <= w_glyph_merged;
                        r_state <= c_st_gly_wr;
                    end else begin
                        r_rdata <= w_glyph_slice;
                        r_state <= c_st_resp;
                    end
                end
                c_st_gly_wr: begin
                    r_state <= c_st_resp;
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign pready         = (r_state == c_st_resp);
    assign pslverr        = pready && r_err;
    assign prdata         = pready ? r_rdata : 32'd0;

    assign ch_map_addr_o  = w_map_addr;
    assign col_map_addr_o = w_map_addr;
    assign ch_map_data_o  = r_wdata[8 * w_lane +: 8];
    assign col_map_data_o = r_wdata[8 * w_lane +: 8];
    assign ch_map_wen_o   = (r_state == c_st_map_wr) && (r_region == c_rg_chmap);
    assign col_map_wen_o  = (r_state == c_st_map_wr) && (r_region == c_rg_colmap);

    assign ch_t_rw_addr_o = r_gidx;
    assign ch_t_rw_data_o = r_glyph;
    assign ch_t_rw_wen_o  = (r_state == c_st_gly_wr);

    assign en_o           = r_en;

endmodule

`default_nettype wire
